// File: rtl/data_mem_access_pkg.sv
// Shared definitions for the core's data-side AXI master: FSM encodings,
// access-size codes and the constant AXI sideband values (also used by inst_fetch).
package data_mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_AR    = 3'd2,
    ST_R     = 3'd3,
    ST_AWW   = 3'd4,
    ST_B     = 3'd5,
    ST_RESP  = 3'd6
  } lsu_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam logic [2:0] AXI_SIZE_4B   = 3'b010;
  localparam logic [1:0] AXI_BURST_INC = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // True when the access cannot be issued: bad size or not naturally aligned.
  function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_access_lsu_align.sv
// Lane steering for RV32I loads/stores: store data replication and byte
// strobes, plus load lane extraction with sign/zero extension. Purely combinational.
module data_mem_access_lsu_align
  import data_mem_access_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        unsigned_ld,
  input  logic [31:0] store_data,
  output logic [31:0] store_wdata,
  output logic [3:0]  store_strb,
  input  logic [31:0] load_raw,
  output logic [31:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Replicate the right-aligned store value across lanes and pick the strobes.
  always_comb begin
    store_wdata = 32'd0;
    store_strb  = 4'b0000;
    case (size)
      SIZE_B: begin
        store_wdata = {4{store_data[7:0]}};
        store_strb  = 4'b0001 << addr_lo;
      end
      SIZE_H: begin
        store_wdata = {2{store_data[15:0]}};
        store_strb  = 4'b0011 << {addr_lo[1], 1'b0};
      end
      SIZE_W: begin
        store_wdata = store_data;
        store_strb  = 4'b1111;
      end
      default: begin
        store_wdata = 32'd0;
        store_strb  = 4'b0000;
      end
    endcase
  end

  // Shift the addressed lane down and extend it to 32 bits.
  always_comb begin
    byte_s    = load_raw[{addr_lo, 3'b000} +: 8];
    half_s    = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    load_data = 32'd0;
    case (size)
      SIZE_B: begin
        if (unsigned_ld) begin
          load_data = {24'd0, byte_s};
        end else begin
          load_data = {{24{byte_s[7]}}, byte_s};
        end
      end
      SIZE_H: begin
        if (unsigned_ld) begin
          load_data = {16'd0, half_s};
        end else begin
          load_data = {{16{half_s[15]}}, half_s};
        end
      end
      SIZE_W:  load_data = load_raw;
      default: load_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// Load/store controller: takes one request at a time from execute, issues a
// single-beat AXI4 read or write, and returns a one-cycle response. Every
// output comes straight from a flop, so nothing depends combinationally on AXI inputs.
module data_mem_access
  import data_mem_access_pkg::*;
#(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 32,
  parameter int C_M_AXI_AWUSER_WIDTH    = 1,
  parameter int C_M_AXI_ARUSER_WIDTH    = 1,
  parameter int C_M_AXI_WUSER_WIDTH     = 4,
  parameter int C_M_AXI_RUSER_WIDTH     = 4,
  parameter int C_M_AXI_BUSER_WIDTH     = 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               REQ_VALID,
  output logic                               REQ_READY,
  input  logic                               REQ_WE,
  input  logic [31:0]                        REQ_ADDR,
  input  logic [1:0]                         REQ_SIZE,
  input  logic                               REQ_UNSIGNED,
  input  logic [31:0]                        REQ_WDATA,
  output logic                               RSP_VALID,
  output logic [31:0]                        RSP_RDATA,
  output logic                               RSP_ERR,
  output logic                               BUSY,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_AWADDR,
  output logic [7:0]                         M_AXI_AWLEN,
  output logic [2:0]                         M_AXI_AWSIZE,
  output logic [1:0]                         M_AXI_AWBURST,
  output logic                               M_AXI_AWLOCK,
  output logic [3:0]                         M_AXI_AWCACHE,
  output logic [2:0]                         M_AXI_AWPROT,
  output logic [3:0]                         M_AXI_AWQOS,
  output logic [C_M_AXI_AWUSER_WIDTH-1:0]    M_AXI_AWUSER,
  output logic                               M_AXI_AWVALID,
  input  logic                               M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]    M_AXI_WSTRB,
  output logic                               M_AXI_WLAST,
  output logic [C_M_AXI_WUSER_WIDTH-1:0]     M_AXI_WUSER,
  output logic                               M_AXI_WVALID,
  input  logic                               M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_BID,
  input  logic [1:0]                         M_AXI_BRESP,
  input  logic [C_M_AXI_BUSER_WIDTH-1:0]     M_AXI_BUSER,
  input  logic                               M_AXI_BVALID,
  output logic                               M_AXI_BREADY,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARLOCK,
  output logic [3:0]                         M_AXI_ARCACHE,
  output logic [2:0]                         M_AXI_ARPROT,
  output logic [3:0]                         M_AXI_ARQOS,
  output logic [C_M_AXI_ARUSER_WIDTH-1:0]    M_AXI_ARUSER,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0] M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]      M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic [C_M_AXI_RUSER_WIDTH-1:0]     M_AXI_RUSER,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY
);

  lsu_state_e  state_r, next_state_s;

  // Latched request
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        we_r;
  logic        uns_r;
  logic [31:0] store_data_r;

  // Registered outputs
  logic        req_ready_r, busy_r;
  logic        arvalid_r, rready_r, awvalid_r, wvalid_r, bready_r;
  logic [31:0] wdata_r;
  logic [3:0]  wstrb_r;
  logic        rsp_valid_r, rsp_err_r;
  logic [31:0] rsp_rdata_r;

  // Next-cycle values
  logic        bad_access_s, aw_done_s, w_done_s;
  logic        rsp_err_next_s;
  logic [31:0] rsp_rdata_next_s;
  logic [31:0] align_wdata_s, load_ext_s;
  logic [3:0]  align_strb_s;

  // ID/USER of responses and RLAST carry no information for single-beat, single-ID traffic.
  logic        unused_s;
  assign unused_s = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_RID, M_AXI_RLAST, M_AXI_RUSER};

  data_mem_access_lsu_align u_lsu_align (
    .size        (size_r),
    .addr_lo     (addr_r[1:0]),
    .unsigned_ld (uns_r),
    .store_data  (store_data_r),
    .store_wdata (align_wdata_s),
    .store_strb  (align_strb_s),
    .load_raw    (M_AXI_RDATA[31:0]),
    .load_data   (load_ext_s)
  );

  // Next state plus the response that will be presented in the RESP cycle.
  always_comb begin
    next_state_s     = state_r;
    rsp_err_next_s   = 1'b0;
    rsp_rdata_next_s = 32'd0;
    bad_access_s     = is_bad_access(size_r, addr_r[1:0]);
    // A channel counts as done once its handshake has happened in this AWW visit.
    aw_done_s        = (state_r == ST_AWW) && (!awvalid_r || M_AXI_AWREADY);
    w_done_s         = (state_r == ST_AWW) && (!wvalid_r || M_AXI_WREADY);
    case (state_r)
      ST_IDLE: begin
        if (REQ_VALID && req_ready_r) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (bad_access_s) begin
          next_state_s   = ST_RESP;
          rsp_err_next_s = 1'b1;
        end else if (we_r) begin
          next_state_s = ST_AWW;
        end else begin
          next_state_s = ST_AR;
        end
      end
      ST_AR: begin
        if (arvalid_r && M_AXI_ARREADY) begin
          next_state_s = ST_R;
        end else begin
          next_state_s = ST_AR;
        end
      end
      ST_R: begin
        if (rready_r && M_AXI_RVALID) begin
          next_state_s = ST_RESP;
          if (M_AXI_RRESP != AXI_RESP_OKAY) begin
            rsp_err_next_s   = 1'b1;
            rsp_rdata_next_s = 32'd0;
          end else begin
            rsp_err_next_s   = 1'b0;
            rsp_rdata_next_s = load_ext_s;
          end
        end else begin
          next_state_s = ST_R;
        end
      end
      ST_AWW: begin
        if (aw_done_s && w_done_s) begin
          next_state_s = ST_B;
        end else begin
          next_state_s = ST_AWW;
        end
      end
      ST_B: begin
        if (bready_r && M_AXI_BVALID) begin
          next_state_s   = ST_RESP;
          rsp_err_next_s = (M_AXI_BRESP != AXI_RESP_OKAY);
        end else begin
          next_state_s = ST_B;
        end
      end
      ST_RESP: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // State, request latch and all registered outputs; RST drops every handshake at once.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= ST_IDLE;
      addr_r       <= 32'd0;
      size_r       <= 2'd0;
      we_r         <= 1'b0;
      uns_r        <= 1'b0;
      store_data_r <= 32'd0;
      req_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      awvalid_r    <= 1'b0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
      wdata_r      <= 32'd0;
      wstrb_r      <= 4'b0000;
      rsp_valid_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      rsp_rdata_r  <= 32'd0;
    end else begin
      state_r <= next_state_s;
      if (state_r == ST_IDLE && REQ_VALID && req_ready_r) begin
        addr_r       <= REQ_ADDR;
        size_r       <= REQ_SIZE;
        we_r         <= REQ_WE;
        uns_r        <= REQ_UNSIGNED;
        store_data_r <= REQ_WDATA;
      end
      if (state_r == ST_CHECK) begin
        wdata_r <= align_wdata_s;
        wstrb_r <= align_strb_s;
      end
      req_ready_r <= (next_state_s == ST_IDLE);
      busy_r      <= (next_state_s != ST_IDLE);
      arvalid_r   <= (next_state_s == ST_AR);
      rready_r    <= (next_state_s == ST_R);
      awvalid_r   <= (next_state_s == ST_AWW) && !aw_done_s;
      wvalid_r    <= (next_state_s == ST_AWW) && !w_done_s;
      bready_r    <= (next_state_s == ST_B);
      rsp_valid_r <= (next_state_s == ST_RESP);
      rsp_err_r   <= rsp_err_next_s;
      rsp_rdata_r <= rsp_rdata_next_s;
    end
  end

  assign REQ_READY = req_ready_r;
  assign BUSY      = busy_r;
  assign RSP_VALID = rsp_valid_r;
  assign RSP_ERR   = rsp_err_r;
  assign RSP_RDATA = rsp_rdata_r;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = C_M_AXI_ADDR_WIDTH'({addr_r[31:2], 2'b00});
  assign M_AXI_AWLEN   = 8'd0;
  assign M_AXI_AWSIZE  = AXI_SIZE_4B;
  assign M_AXI_AWBURST = AXI_BURST_INC;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = AXI_CACHE_DEF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = awvalid_r;

  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = wstrb_r;
  assign M_AXI_WLAST   = 1'b1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = wvalid_r;

  assign M_AXI_BREADY  = bready_r;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = C_M_AXI_ADDR_WIDTH'({addr_r[31:2], 2'b00});
  assign M_AXI_ARLEN   = 8'd0;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INC;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = AXI_CACHE_DEF;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = arvalid_r;

  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: directed scenarios plus randomized requests against
// a responsive AXI slave with random delays and response codes. Expected values
// come from a behavioural model of the load/store rules.
module tb_data_mem_access;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID, REQ_READY, REQ_WE, REQ_UNSIGNED;
  logic [31:0] REQ_ADDR, REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        RSP_VALID, RSP_ERR, BUSY;
  logic [31:0] RSP_RDATA;
  logic [0:0]  AWID, ARID, BID, RID, AWUSER, ARUSER, BUSER;
  logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE, AWPROT, ARPROT;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWLOCK, ARLOCK, AWVALID, AWREADY, WLAST, WVALID, WREADY;
  logic [3:0]  AWCACHE, ARCACHE, AWQOS, ARQOS, WSTRB, WUSER, RUSER;
  logic        BVALID, BREADY, ARVALID, ARREADY, RLAST, RVALID, RREADY;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  data_mem_access dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE), .REQ_ADDR(REQ_ADDR),
    .REQ_SIZE(REQ_SIZE), .REQ_UNSIGNED(REQ_UNSIGNED), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN), .M_AXI_AWSIZE(AWSIZE),
    .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK), .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT),
    .M_AXI_AWQOS(AWQOS), .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST), .M_AXI_WUSER(WUSER),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARID(ARID), .M_AXI_ARADDR(ARADDR), .M_AXI_ARLEN(ARLEN), .M_AXI_ARSIZE(ARSIZE),
    .M_AXI_ARBURST(ARBURST), .M_AXI_ARLOCK(ARLOCK), .M_AXI_ARCACHE(ARCACHE), .M_AXI_ARPROT(ARPROT),
    .M_AXI_ARQOS(ARQOS), .M_AXI_ARUSER(ARUSER), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RID(RID), .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RLAST(RLAST),
    .M_AXI_RUSER(RUSER), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_bad(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input bit uns,
                                             input logic [31:0] addr, input logic [31:0] raw);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (raw >> (8 * (addr % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (raw >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v + 32'hFFFF_0000;
    end else begin
      v = raw;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] wd);
    if (size == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_wstrb(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd0) return 32'd1 << (addr % 4);
    if (size == 2'd1) return 32'd3 << (2 * ((addr / 2) % 2));
    return 32'd15;
  endfunction

  task automatic idle_slave();
    ARREADY = 1'b0; RVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0;
    RRESP = 2'b00; BRESP = 2'b00; RDATA = 32'd0;
  endtask

  // One complete request, called and returning on a falling edge. The slave
  // below answers with the given delays, response code and read data.
  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wd,
                         input int ar_dly, input int r_dly, input int aw_dly, input int w_dly,
                         input int b_dly, input logic [1:0] resp, input logic [31:0] rd);
    bit          bad, exp_err, fin;
    bit          ar_done, r_done, aw_done, w_done, b_done;
    int          ar_seen, r_cnt, aw_seen, w_seen, b_cnt;
    int          n_ar, n_r, n_aw, n_w, n_b, n_rsp, rsp_cyc, cyc, exp_cyc;
    int          e_ar, e_r, e_aw, e_w, e_b;
    logic [31:0] exp_rd, got_araddr, got_awaddr, got_wdata, got_rdata;
    logic [3:0]  got_wstrb;
    logic        got_wlast, got_err;
    {ar_done, r_done, aw_done, w_done, b_done, fin} = '0;
    {ar_seen, r_cnt, aw_seen, w_seen, b_cnt} = '0;
    {n_ar, n_r, n_aw, n_w, n_b, n_rsp, rsp_cyc} = '0;
    got_araddr = 32'd0; got_awaddr = 32'd0; got_wdata = 32'd0; got_wstrb = 4'd0;
    got_wlast = 1'b0; got_err = 1'b0; got_rdata = 32'd0;

    bad     = model_bad(size, addr);
    exp_err = bad || (resp != 2'b00);
    exp_rd  = (exp_err || we) ? 32'd0 : model_load(size, uns, addr, rd);
    e_ar = (!bad && !we) ? ar_dly + 1 : 0;
    e_r  = (!bad && !we) ? r_dly + 1 : 0;
    e_aw = (!bad && we) ? aw_dly + 1 : 0;
    e_w  = (!bad && we) ? w_dly + 1 : 0;
    e_b  = (!bad && we) ? b_dly + 1 : 0;
    if (bad)     exp_cyc = 2;
    else if (we) exp_cyc = 4 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
    else         exp_cyc = 4 + ar_dly + r_dly;

    // cycle 0: present the request
    check_val("req_ready_idle", 32'(REQ_READY), 32'd1);
    REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = addr; REQ_SIZE = size;
    REQ_UNSIGNED = uns; REQ_WDATA = wd;
    idle_slave();
    @(negedge CLK);
    cyc = 1;
    check_val("busy_after_accept", 32'(BUSY), 32'd1);
    check_val("req_ready_busy", 32'(REQ_READY), 32'd0);

    while (!fin && cyc <= 60) begin
      // A junk request stays offered while busy; it must be ignored.
      REQ_VALID = 1'b1; REQ_WE = 1'($urandom); REQ_ADDR = $urandom;
      REQ_SIZE = 2'($urandom); REQ_UNSIGNED = 1'($urandom); REQ_WDATA = $urandom;
      if (ARVALID) n_ar++;
      if (RREADY)  n_r++;
      if (AWVALID) n_aw++;
      if (WVALID)  n_w++;
      if (BREADY)  n_b++;
      if (RSP_VALID) begin
        n_rsp++; rsp_cyc = cyc; got_err = RSP_ERR; got_rdata = RSP_RDATA;
        REQ_VALID = 1'b0;
      end
      // Response channels first so they see only handshakes from earlier cycles.
      RVALID = 1'b0;
      if (ar_done && !r_done) begin
        if (r_cnt >= r_dly) begin
          RVALID = 1'b1; RDATA = rd; RRESP = resp;
          if (RREADY) r_done = 1'b1;
        end else r_cnt++;
      end else RDATA = $urandom;
      BVALID = 1'b0;
      if (aw_done && w_done && !b_done) begin
        if (b_cnt >= b_dly) begin
          BVALID = 1'b1; BRESP = resp;
          if (BREADY) b_done = 1'b1;
        end else b_cnt++;
      end
      ARREADY = 1'b0;
      if (ARVALID && !ar_done) begin
        if (ar_seen >= ar_dly) begin
          ARREADY = 1'b1; ar_done = 1'b1; got_araddr = ARADDR;
        end else ar_seen++;
      end
      AWREADY = 1'b0;
      if (AWVALID && !aw_done) begin
        if (aw_seen >= aw_dly) begin
          AWREADY = 1'b1; aw_done = 1'b1; got_awaddr = AWADDR;
        end else aw_seen++;
      end
      WREADY = 1'b0;
      if (WVALID && !w_done) begin
        if (w_seen >= w_dly) begin
          WREADY = 1'b1; w_done = 1'b1; got_wdata = WDATA; got_wstrb = WSTRB; got_wlast = WLAST;
        end else w_seen++;
      end
      @(negedge CLK);
      if (n_rsp > 0 && rsp_cyc == cyc) fin = 1'b1;
      cyc++;
    end
    REQ_VALID = 1'b0;
    idle_slave();

    check_val("rsp_count", 32'(n_rsp), 32'd1);
    check_val("rsp_cycle", 32'(rsp_cyc), 32'(exp_cyc));
    check_val("rsp_err", 32'(got_err), 32'(exp_err));
    check_val("rsp_rdata", got_rdata, exp_rd);
    check_val("arvalid_cycles", 32'(n_ar), 32'(e_ar));
    check_val("rready_cycles", 32'(n_r), 32'(e_r));
    check_val("awvalid_cycles", 32'(n_aw), 32'(e_aw));
    check_val("wvalid_cycles", 32'(n_w), 32'(e_w));
    check_val("bready_cycles", 32'(n_b), 32'(e_b));
    if (!bad && !we) check_val("araddr", got_araddr, addr & 32'hFFFF_FFFC);
    if (!bad && we) begin
      check_val("awaddr", got_awaddr, addr & 32'hFFFF_FFFC);
      check_val("wdata", got_wdata, model_wdata(size, wd));
      check_val("wstrb", 32'(got_wstrb), model_wstrb(size, addr));
      check_val("wlast", 32'(got_wlast), 32'd1);
    end
    if (fin) begin
      check_val("rsp_single_pulse", 32'(RSP_VALID), 32'd0);
      check_val("ready_after_rsp", 32'(REQ_READY), 32'd1);
      check_val("busy_after_rsp", 32'(BUSY), 32'd0);
    end else begin
      // Stuck: recover with a reset so the remaining transactions still run.
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
    end
  endtask

  initial begin
    bit          found;
    bit          we, uns;
    logic [31:0] addr;
    logic [1:0]  size, resp;
    int          r;

    RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = 32'd0; REQ_SIZE = 2'd0;
    REQ_UNSIGNED = 1'b0; REQ_WDATA = 32'd0;
    BID = 1'b0; RID = 1'b0; BUSER = 1'b0; RUSER = 4'd0; RLAST = 1'b1;
    idle_slave();
    repeat (3) @(negedge CLK);

    check_val("rst_req_ready", 32'(REQ_READY), 32'd1);
    check_val("rst_busy", 32'(BUSY), 32'd0);
    check_val("rst_valids", {27'd0, ARVALID, AWVALID, WVALID, RSP_VALID, RSP_ERR}, 32'd0);
    check_val("rst_readys", {30'd0, BREADY, RREADY}, 32'd0);
    check_val("rst_rdata", RSP_RDATA, 32'd0);
    RST = 1'b0;
    @(negedge CLK);

    // Directed scenarios (args: we addr size uns wdata ar r aw w b resp rdata)
    run_txn(1'b0, 32'h2000_0104, 2'd2, 1'b0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF);
    run_txn(1'b0, 32'h2000_0103, 2'd0, 1'b0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h80FF_0000);
    run_txn(1'b0, 32'h2000_0103, 2'd0, 1'b1, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h80FF_0000);
    run_txn(1'b1, 32'h2000_0102, 2'd1, 1'b0, 32'h0000_1234, 0, 0, 3, 0, 0, 2'b00, 32'd0);
    run_txn(1'b0, 32'h2000_0101, 2'd2, 1'b0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h1111_1111);
    run_txn(1'b1, 32'h2000_0200, 2'd2, 1'b0, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 2'b10, 32'd0);
    run_txn(1'b0, 32'h2000_0202, 2'd1, 1'b0, 32'd0, 1, 2, 0, 0, 0, 2'b00, 32'h9234_5678);
    run_txn(1'b1, 32'h2000_0301, 2'd0, 1'b0, 32'h0000_00A5, 0, 0, 0, 2, 1, 2'b00, 32'd0);
    run_txn(1'b0, 32'h2000_0300, 2'd3, 1'b0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'd0);

    // Reset while waiting in R with RVALID low
    REQ_VALID = 1'b1; REQ_WE = 1'b0; REQ_ADDR = 32'h2000_0400; REQ_SIZE = 2'd2; REQ_UNSIGNED = 1'b0;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (RREADY) begin
        found = 1'b1;
      end else begin
        ARREADY = ARVALID;
        @(negedge CLK);
      end
    end
    check_val("rst_reach_r", 32'(found), 32'd1);
    ARREADY = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    check_val("midrst_valids", {28'd0, ARVALID, AWVALID, WVALID, RSP_VALID}, 32'd0);
    check_val("midrst_readys", {30'd0, BREADY, RREADY}, 32'd0);
    check_val("midrst_req_ready", 32'(REQ_READY), 32'd1);
    check_val("midrst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    run_txn(1'b0, 32'h2000_0400, 2'd2, 1'b0, 32'd0, 0, 0, 0, 0, 0, 2'b00, 32'h0BAD_F00D);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      we   = 1'($urandom);
      uns  = 1'($urandom);
      size = 2'($urandom_range(0, 3));
      addr = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (size == 2'd1) addr = addr & 32'hFFFF_FFFE;
        if (size == 2'd2) addr = addr & 32'hFFFF_FFFC;
      end
      r    = $urandom_range(0, 7);
      resp = (r < 5) ? 2'b00 : 2'(r - 4);
      run_txn(we, addr, size, uns, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), resp, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_access.md
Name: data_mem_access

Overview:
- Load/store controller that sequences the core's data AXI4 master port, replacing the current tie-offs.
- Accepts one load/store request at a time from the execute stage and issues a single-beat AXI read or write.
- Performs RV32I byte/halfword lane steering, strobe generation and sign/zero extension.
- Returns a response and drives a BUSY flag, which core ORs into its global stall.

Parameters:
C_M_AXI_THREAD_ID_WIDTH, 1, width of AWID/ARID/BID/RID
C_M_AXI_ADDR_WIDTH, 32, AXI address width
C_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported
C_M_AXI_AWUSER_WIDTH, 1, AWUSER width
C_M_AXI_ARUSER_WIDTH, 1, ARUSER width
C_M_AXI_WUSER_WIDTH, 4, WUSER width
C_M_AXI_RUSER_WIDTH, 4, RUSER width (ignored)
C_M_AXI_BUSER_WIDTH, 1, BUSER width (ignored)

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
REQ_VALID  in  1  request present
REQ_READY  out  1  request accepted when VALID&&READY
REQ_WE  in  1  1=store, 0=load
REQ_ADDR  in  32  byte address
REQ_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal
REQ_UNSIGNED  in  1  load zero-extends (LBU/LHU)
REQ_WDATA  in  32  store data, right-aligned
RSP_VALID  out  1  one-cycle response pulse
RSP_RDATA  out  32  extended load data (0 for stores)
RSP_ERR  out  1  misaligned/illegal size or non-OKAY RESP
BUSY  out  1  request held or in flight
M_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WLAST/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY  standard AXI4 directions and widths
M_AXI_AW*/AR* sideband (ID, LEN, SIZE, BURST, LOCK, CACHE, PROT, QOS, USER), WUSER  out  constants: ID=0, LEN=0, SIZE=3'b010, BURST=01, LOCK=0, CACHE=0011, PROT=0, QOS=0, USER=0

Behaviour:
- FSM states: IDLE, CHECK, AR, R, AWW, B, RESP.
- Reset values: state=IDLE; all VALIDs 0; BREADY=0; RREADY=0; RSP_VALID=0; RSP_RDATA=0; RSP_ERR=0; BUSY=0; REQ_READY=1.
- Request capture:
  - REQ_READY=1 only in IDLE.
  - On handshake, latch addr, size, we, unsigned flag and wdata; go to CHECK.
  - BUSY=1 from the cycle after acceptance through the RESP cycle inclusive.
- CHECK: misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size=3 → RESP with ERR=1 and no bus activity. Otherwise → AR (load) or AWW (store).
- AR: ARVALID=1 with ARADDR={addr[31:2],2'b00}, held stable until ARREADY; then → R.
- R: RREADY=1. On RVALID:
  - capture RDATA and RRESP → RESP.
  - Lane = addr[1:0] (byte) or addr[1] (half); shift right, then sign/zero extend.
- AWW:
  - AWVALID and WVALID asserted together; each drops independently on its own handshake.
  - WLAST=1.
  - Leave only when both handshakes are done (same or different cycles) → B.
  - AWADDR is word-aligned.
  - WDATA: byte={4{b}}, half={2{h}}, word=as is.
  - WSTRB: byte=0001<<addr[1:0], half=0011<<{addr[1],1'b0}, word=1111.
- B: BREADY=1. On BVALID → RESP.
- RESP:
  - RSP_VALID=1 for exactly one cycle; ERR=1 if RRESP/BRESP!=00; RSP_RDATA=0 on store or error.
  - → IDLE, REQ_READY=1 the next cycle.
- Minimum latency, zero-wait slave (acceptance = cycle 0):
  - load: AR at c2, R at c3, RSP_VALID at c4.
  - store: AW/W at c2, B at c3, RSP_VALID at c4.
- No outputs are combinationally dependent on AXI inputs.
- RST mid-transaction returns to IDLE immediately and drops all VALID/READY. The interconnect is reset with the core, so orphaned responses do not occur.
- Back-to-back requests: the next request is accepted the cycle after RESP; there is no pipelining.

Decomposition:
- Shared package holds FSM state encodings, the SIZE_B/H/W constants, and the AXI constant sideband values (CACHE, BURST, SIZE) so inst_fetch can reuse them.
- One natural sub-module, lsu_align: combinational strobe/WDATA replication plus load extract/extend, testable standalone.

Test Plan:
1. LW 0x2000_0104, slave returns 0xDEADBEEF OKAY with zero wait → ARADDR=0x2000_0104, RSP_VALID at cycle 4, RSP_RDATA=0xDEADBEEF, ERR=0.
2. LB addr 0x...0103 with RDATA 0x80FF_0000 → RSP_RDATA=0xFFFF_FF80; same request as LBU → 0x0000_0080.
3. SH addr 0x...0102, WDATA 0x0000_1234; AWREADY delayed 3 cycles, WREADY immediate → WDATA=0x1234_1234, WSTRB=1100, WVALID drops after 1 cycle, AWVALID held, single RSP_VALID.
4. LW addr 0x...0101 → no ARVALID ever, RSP_VALID with ERR=1 two cycles after acceptance.
5. SW with BRESP=2'b10 (SLVERR) → RSP_ERR=1, RSP_RDATA=0; next request accepted the following cycle.
6. RST asserted while in R with RVALID low → next cycle all VALID/READY=0, REQ_READY=1, BUSY=0; a fresh LW then completes normally.
